// File: rtl/sub_divider_ctrl.sv
// Sequential restoring divider: one subtract-shift step per cycle, WIDTH steps per operation.
// Division by zero finishes at once with an all-ones quotient and the dividend as remainder.
module sub_divider_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request that is taken on a rising edge only while busy=0
    // (IDLE or DONE); a and b are captured on that edge, and done pulses for one
    // cycle when the matching results appear on quotient/remainder/div_by_zero.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH:0]   rem_r, rem_n;
    logic [WIDTH-1:0] q_r, q_n;
    logic [WIDTH-1:0] b_r, b_n;
    logic [WIDTH-1:0] quo_n, rmd_n;
    logic             dbz_n;
    logic [WIDTH:0]   rs, diff;
    logic             take_bit;

    assign rs       = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
    assign diff     = rs - {1'b0, b_r};
    assign take_bit = ~diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            b_r         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rem_r       <= rem_n;
            q_r         <= q_n;
            b_r         <= b_n;
            quotient    <= quo_n;
            remainder   <= rmd_n;
            div_by_zero <= dbz_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem_r;
        q_n     = q_r;
        b_n     = b_r;
        quo_n   = quotient;
        rmd_n   = remainder;
        dbz_n   = div_by_zero;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    if (b != '0) begin
                        // The dividend rides in q_r and is shifted out MSB first.
                        q_n     = a;
                        b_n     = b;
                        rem_n   = '0;
                        cnt_n   = CW'(WIDTH - 1);
                        state_n = RUN;
                    end else begin
                        quo_n   = '1;
                        rmd_n   = a;
                        dbz_n   = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                rem_n = take_bit ? diff : rs;
                q_n   = {q_r[WIDTH-2:0], take_bit};
                cnt_n = cnt - CW'(1);
                if (cnt == '0) begin
                    quo_n   = q_n;
                    rmd_n   = rem_n[WIDTH-1:0];
                    dbz_n   = 1'b0;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: doc/sub_divider_ctrl.md
SUB_DIVIDER_CTRL -- requirements
Module: sub_divider_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand width; all other widths derive from it.
REQ-002 clk  input  1  single clock; all sequential state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request pulse; sampled at the clk edge, accepted only when busy=0.
REQ-005 a  input  WIDTH  dividend, unsigned; latched on the accepting edge.
REQ-006 b  input  WIDTH  divisor, unsigned; latched on the accepting edge.
REQ-007 busy  output  1  high while the subtract-shift sequence runs.
REQ-008 done  output  1  single-cycle completion pulse.
REQ-009 quotient  output  WIDTH  result quotient, held until next completion.
REQ-010 remainder  output  WIDTH  result remainder, held until next completion.
REQ-011 div_by_zero  output  1  flag for the latest completed operation, held with the results.

Function
REQ-012 States SHALL be IDLE, RUN, DONE.
REQ-013 IDLE: start=1 and b!=0 SHALL latch a and b, clear partial remainder R (WIDTH+1 bits), load the iteration counter with WIDTH-1, and go to RUN.
REQ-014 IDLE: start=1 and b==0 SHALL go directly to DONE with quotient=all ones, remainder=a, div_by_zero=1 (1-cycle latency).
REQ-015 RUN iteration, once per cycle: Rs={R[WIDTH-1:0], Qreg[MSB]}, Qreg shifted left by 1; diff=Rs-{1'b0,b} computed WIDTH+1 bits wide; diff[WIDTH]==0 -> R=diff, new Qreg LSB=1; else R=Rs, LSB=0.
REQ-016 RUN SHALL perform exactly WIDTH iterations; the counter decrements each iteration; when the counter is 0, the iteration SHALL also write quotient=Qreg result, remainder=R[WIDTH-1:0], div_by_zero=0 and go to DONE.
REQ-017 Latency SHALL be WIDTH+1 edges from the accepting edge to the first edge sampling done=1 (33 for WIDTH=32).
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; DONE SHALL last one cycle.
REQ-019 DONE with start=1 SHALL accept the new operation (back-to-back) as in IDLE; otherwise DONE SHALL go to IDLE.
REQ-020 start in RUN SHALL be ignored with no effect on state, operands or outputs.
REQ-021 Changes on a/b after acceptance SHALL NOT affect the running operation.
REQ-022 quotient, remainder and div_by_zero SHALL change only on completion (DONE entry) or reset.
REQ-023 All subtraction SHALL be unsigned, with borrow taken from bit WIDTH of the WIDTH+1-bit difference; no signed interpretation anywhere.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force state to IDLE, counter, R and Qreg to 0, and busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-025 Reset during RUN SHALL abort the operation; no done pulse SHALL follow it, and the first start after rst deasserts SHALL be accepted normally.
REQ-026 start asserted while rst=1 SHALL be ignored.

Verification
REQ-027 a=100, b=7, start pulse -> busy for 32 cycles, done at edge 33: quotient=14, remainder=2, div_by_zero=0.
REQ-028 a=0xFFFFFFFF, b=1 -> quotient=0xFFFFFFFF, remainder=0; then a=3, b=0x80000000 -> quotient=0, remainder=3.
REQ-029 a=5, b=0 -> done on the next cycle, busy never high: quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-030 a=0x2F049181, b=0x4070C471, with start re-pulsed and a/b changed mid-RUN -> result unaffected: quotient=0, remainder=0x2F049181; only one done pulse.
REQ-031 rst pulsed asynchronously (between edges) at iteration 10 of 1000/3 -> all outputs 0 immediately, no done; then 1000/3 -> quotient=333, remainder=1.
REQ-032 start held high through DONE of 100/7 with next operands 0xABF4AAAF/0x803FFC00 -> back-to-back acceptance: quotient=1, remainder=0x2BB4AEAF.
